// File: rtl/vscale_htif_multi_monitor.sv
// Host-side tohost monitor for one or more vscale cores.
// Polls each core's tohost CSR round-robin over its HTIF PCR port, optionally
// clears it after a nonzero read, and folds pass/fail/timeout into one status.
module vscale_htif_multi_monitor #(
    parameter int          N_CORES      = 2,
    parameter int          PCR_WIDTH    = 64,
    parameter logic [11:0] TOHOST_ADDR  = 12'h780,
    parameter logic [63:0] MAX_CYCLES   = 64'd0,
    parameter int          RESP_TIMEOUT = 256,
    parameter bit          CLEAR_TOHOST = 1'b1,
    parameter int          CORE_W       = $clog2(N_CORES > 1 ? N_CORES : 2)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           pause,
    output logic [N_CORES-1:0]             htif_pcr_req_valid,
    input  logic [N_CORES-1:0]             htif_pcr_req_ready,
    output logic                           htif_pcr_req_rw,
    output logic [11:0]                    htif_pcr_req_addr,
    output logic [PCR_WIDTH-1:0]           htif_pcr_req_data,
    input  logic [N_CORES-1:0]             htif_pcr_resp_valid,
    output logic [N_CORES-1:0]             htif_pcr_resp_ready,
    input  logic [N_CORES*PCR_WIDTH-1:0]   htif_pcr_resp_data,
    output logic                           done,
    output logic                           pass,
    output logic                           fail,
    output logic                           timeout,
    output logic [CORE_W-1:0]              fail_core,
    output logic [PCR_WIDTH-2:0]           fail_code,
    output logic [N_CORES-1:0]             passed_mask,
    output logic [63:0]                    cycle_count
);

    // state     | meaning
    // S_REQ_RD  | read request to core cur outstanding
    // S_RESP_RD | waiting for tohost read data from core cur
    // S_REQ_WR  | clear (write 0) request to core cur outstanding
    // S_RESP_WR | waiting for clear write response from core cur
    // S_NEXT    | pick next unpassed core, or finish if all passed
    // S_DONE    | run finished, bus idle until reset
    typedef enum logic [2:0] {
        S_REQ_RD, S_RESP_RD, S_REQ_WR, S_RESP_WR, S_NEXT, S_DONE
    } state_t;

    localparam logic [31:0] HS_LOAD = 32'(RESP_TIMEOUT - 1);

    state_t                 state, state_nxt;
    logic [CORE_W-1:0]      cur, cur_nxt, next_idx;
    logic [31:0]            hs_cnt;
    logic                   active;
    logic                   step, in_hs, hs_event, hs_to, glob_to, rd_sample;
    logic                   sel_req_ready, sel_resp_valid, found;
    logic [PCR_WIDTH-1:0]   resp_d;
    logic [N_CORES-1:0]     cur_onehot;
    logic                   d_pass, d_fail;

    // Select the handshake signals and data of the core currently polled.
    always_comb begin
        sel_req_ready  = 1'b0;
        sel_resp_valid = 1'b0;
        resp_d         = '0;
        cur_onehot     = '0;
        for (int k = 0; k < N_CORES; k++) begin
            if (cur == CORE_W'(k)) begin
                sel_req_ready  = htif_pcr_req_ready[k];
                sel_resp_valid = htif_pcr_resp_valid[k];
                resp_d         = htif_pcr_resp_data[k*PCR_WIDTH +: PCR_WIDTH];
                cur_onehot[k]  = 1'b1;
            end
        end
    end

    // Round-robin search for the next core that has not yet reported pass.
    always_comb begin
        next_idx = cur;
        found    = 1'b0;
        for (int i = 1; i <= N_CORES; i++) begin
            if (!found && !passed_mask[(int'(cur) + i) % N_CORES]) begin
                next_idx = CORE_W'((int'(cur) + i) % N_CORES);
                found    = 1'b1;
            end
        end
    end

    // active masks the first cycle after reset so all outputs read 0 during reset.
    assign step      = active && !pause;
    assign in_hs     = (state == S_REQ_RD) || (state == S_RESP_RD) ||
                       (state == S_REQ_WR) || (state == S_RESP_WR);
    assign hs_event  = (state == S_REQ_RD || state == S_REQ_WR) ? sel_req_ready : sel_resp_valid;
    assign hs_to     = step && in_hs && !hs_event && (hs_cnt == 32'd0);
    assign glob_to   = step && (MAX_CYCLES != 64'd0) && (state != S_DONE) &&
                       (cycle_count == MAX_CYCLES - 64'd1);
    assign rd_sample = step && (state == S_RESP_RD) && sel_resp_valid;
    assign d_pass    = (resp_d == PCR_WIDTH'(1));
    assign d_fail    = (resp_d != '0) && !d_pass;

    // State, core pointer, handshake down-counter and cycle counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_REQ_RD;
            cur         <= '0;
            hs_cnt      <= HS_LOAD;
            active      <= 1'b0;
            cycle_count <= 64'd0;
        end else begin
            active <= 1'b1;
            state  <= state_nxt;
            cur    <= cur_nxt;
            if (step) begin
                if (state_nxt != state)
                    hs_cnt <= HS_LOAD;
                else if (hs_cnt != 32'd0)
                    hs_cnt <= hs_cnt - 32'd1;
                if (state != S_DONE)
                    cycle_count <= cycle_count + 64'd1;
            end
        end
    end

    // Next-state logic; a global timeout overrides whatever the FSM would do.
    always_comb begin
        state_nxt = state;
        cur_nxt   = cur;
        if (step) begin
            case (state)
                S_REQ_RD:  if (sel_req_ready) state_nxt = S_RESP_RD;
                           else if (hs_to)    state_nxt = S_DONE;
                S_RESP_RD: if (sel_resp_valid) begin
                               if (d_pass)      state_nxt = CLEAR_TOHOST ? S_REQ_WR : S_NEXT;
                               else if (d_fail) state_nxt = CLEAR_TOHOST ? S_REQ_WR : S_DONE;
                               else             state_nxt = S_NEXT;
                           end else if (hs_to) state_nxt = S_DONE;
                S_REQ_WR:  if (sel_req_ready) state_nxt = S_RESP_WR;
                           else if (hs_to)    state_nxt = S_DONE;
                S_RESP_WR: if (sel_resp_valid) state_nxt = fail ? S_DONE : S_NEXT;
                           else if (hs_to)     state_nxt = S_DONE;
                S_NEXT:    if (&passed_mask) state_nxt = S_DONE;
                           else begin
                               state_nxt = S_REQ_RD;
                               cur_nxt   = next_idx;
                           end
                default:   state_nxt = S_DONE;
            endcase
            if (glob_to) state_nxt = S_DONE;
        end
    end

    // Sticky result flags; only the first error is recorded in fail_core/fail_code.
    always_ff @(posedge clk) begin
        if (reset) begin
            pass        <= 1'b0;
            fail        <= 1'b0;
            timeout     <= 1'b0;
            fail_core   <= '0;
            fail_code   <= '0;
            passed_mask <= '0;
        end else if (step) begin
            if (rd_sample && d_pass)
                passed_mask <= passed_mask | cur_onehot;
            if (((rd_sample && d_fail) || hs_to || glob_to) && !fail && !timeout)
                fail_core <= cur;
            if (rd_sample && d_fail && !fail) begin
                fail      <= 1'b1;
                fail_code <= resp_d[PCR_WIDTH-1:1];
            end
            if (hs_to || glob_to)
                timeout <= 1'b1;
            if ((state == S_NEXT && &passed_mask) ||
                (glob_to && rd_sample && d_pass && &(passed_mask | cur_onehot)))
                pass <= 1'b1;
        end
    end

    // Bus outputs decoded from state; everything idle while in reset.
    always_comb begin
        htif_pcr_req_valid  = '0;
        htif_pcr_resp_ready = '0;
        htif_pcr_req_rw     = 1'b0;
        htif_pcr_req_addr   = active ? TOHOST_ADDR : 12'h000;
        htif_pcr_req_data   = '0;
        done                = 1'b0;
        if (active) begin
            case (state)
                S_REQ_RD:  htif_pcr_req_valid = cur_onehot;
                S_RESP_RD: htif_pcr_resp_ready = cur_onehot;
                S_REQ_WR:  begin
                    htif_pcr_req_valid = cur_onehot;
                    htif_pcr_req_rw    = 1'b1;
                end
                S_RESP_WR: begin
                    htif_pcr_resp_ready = cur_onehot;
                    htif_pcr_req_rw     = 1'b1;
                end
                S_DONE:    done = 1'b1;
                default:   ;
            endcase
        end
    end

endmodule

// File: tb/tb_vscale_htif_multi_monitor.sv
// Bench for vscale_htif_multi_monitor: three configurations share one
// behavioural two-core HTIF responder; unselected instances are held in reset.
module tb_vscale_htif_multi_monitor;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int   n_tests = 0;
    int   n_fail  = 0;

    int   sel      = 0;
    logic tb_reset = 1'b1;
    logic pause    = 1'b0;

    // responder controls
    logic [1:0]  rdy_en = 2'b11;
    logic [1:0]  rv_en  = 2'b11;
    logic        slave_clr = 1'b1;
    logic [63:0] tohost [2];

    // responder state
    logic [1:0]  pend = 2'b00, pend_rw = 2'b00;
    int          rd_cnt [2];
    logic        saw_rw = 1'b0;
    int          act_wr[$];
    int          exp_wr[$];

    // per-instance outputs
    logic [1:0]  o_rv [3], o_rr [3], o_pm [3];
    logic        o_rw [3], o_done [3], o_pass [3], o_fail [3], o_to [3], o_fcore [3];
    logic [11:0] o_addr [3];
    logic [63:0] o_wd [3], o_cc [3];
    logic [62:0] o_fcode [3];

    // shared bus
    logic [1:0]   req_valid, req_ready, resp_valid, resp_ready;
    logic         req_rw;
    logic [11:0]  req_addr;
    logic [63:0]  req_data;
    logic [127:0] resp_data;

    logic         done, pass, fail, timeout, fail_core;
    logic [62:0]  fail_code;
    logic [1:0]   passed_mask;
    logic [63:0]  cycle_count;

    assign req_ready  = rdy_en & ~pend;
    assign resp_valid = pend & rv_en;
    assign resp_data  = {pend_rw[1] ? 64'd0 : tohost[1], pend_rw[0] ? 64'd0 : tohost[0]};

    always_comb begin
        req_valid   = o_rv[0] | o_rv[1] | o_rv[2];
        resp_ready  = o_rr[0] | o_rr[1] | o_rr[2];
        req_rw      = o_rw[0] | o_rw[1] | o_rw[2];
        req_addr    = o_addr[0] | o_addr[1] | o_addr[2];
        req_data    = o_wd[0] | o_wd[1] | o_wd[2];
        done        = o_done[sel];
        pass        = o_pass[sel];
        fail        = o_fail[sel];
        timeout     = o_to[sel];
        fail_core   = o_fcore[sel];
        fail_code   = o_fcode[sel];
        passed_mask = o_pm[sel];
        cycle_count = o_cc[sel];
    end

    vscale_htif_multi_monitor u_dflt (
        .clk(clk), .reset(tb_reset || sel != 0), .pause(pause),
        .htif_pcr_req_valid(o_rv[0]), .htif_pcr_req_ready(req_ready),
        .htif_pcr_req_rw(o_rw[0]), .htif_pcr_req_addr(o_addr[0]), .htif_pcr_req_data(o_wd[0]),
        .htif_pcr_resp_valid(resp_valid), .htif_pcr_resp_ready(o_rr[0]), .htif_pcr_resp_data(resp_data),
        .done(o_done[0]), .pass(o_pass[0]), .fail(o_fail[0]), .timeout(o_to[0]),
        .fail_core(o_fcore[0]), .fail_code(o_fcode[0]), .passed_mask(o_pm[0]), .cycle_count(o_cc[0]));

    vscale_htif_multi_monitor #(.MAX_CYCLES(64'd100)) u_lim (
        .clk(clk), .reset(tb_reset || sel != 1), .pause(pause),
        .htif_pcr_req_valid(o_rv[1]), .htif_pcr_req_ready(req_ready),
        .htif_pcr_req_rw(o_rw[1]), .htif_pcr_req_addr(o_addr[1]), .htif_pcr_req_data(o_wd[1]),
        .htif_pcr_resp_valid(resp_valid), .htif_pcr_resp_ready(o_rr[1]), .htif_pcr_resp_data(resp_data),
        .done(o_done[1]), .pass(o_pass[1]), .fail(o_fail[1]), .timeout(o_to[1]),
        .fail_core(o_fcore[1]), .fail_code(o_fcode[1]), .passed_mask(o_pm[1]), .cycle_count(o_cc[1]));

    vscale_htif_multi_monitor #(.CLEAR_TOHOST(1'b0)) u_noclr (
        .clk(clk), .reset(tb_reset || sel != 2), .pause(pause),
        .htif_pcr_req_valid(o_rv[2]), .htif_pcr_req_ready(req_ready),
        .htif_pcr_req_rw(o_rw[2]), .htif_pcr_req_addr(o_addr[2]), .htif_pcr_req_data(o_wd[2]),
        .htif_pcr_resp_valid(resp_valid), .htif_pcr_resp_ready(o_rr[2]), .htif_pcr_resp_data(resp_data),
        .done(o_done[2]), .pass(o_pass[2]), .fail(o_fail[2]), .timeout(o_to[2]),
        .fail_core(o_fcore[2]), .fail_code(o_fcode[2]), .passed_mask(o_pm[2]), .cycle_count(o_cc[2]));

    // Behavioural HTIF PCR responder: one outstanding transaction per core.
    always @(posedge clk) begin
        if (slave_clr) begin
            pend      <= 2'b00;
            pend_rw   <= 2'b00;
            rd_cnt[0] <= 0;
            rd_cnt[1] <= 0;
            saw_rw    <= 1'b0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (resp_valid[k] && resp_ready[k]) begin
                    pend[k] <= 1'b0;
                    if (pend_rw[k]) act_wr.push_back(k);
                    else rd_cnt[k] <= rd_cnt[k] + 1;
                end
                if (req_valid[k] && req_ready[k]) begin
                    pend[k]    <= 1'b1;
                    pend_rw[k] <= req_rw;
                end
            end
            if (req_rw) saw_rw <= 1'b1;
        end
    end

    task automatic hold_reset(input int new_sel);
        @(negedge clk);
        tb_reset  = 1'b1;
        slave_clr = 1'b1;
        pause     = 1'b0;
        sel       = new_sel;
        repeat (2) @(posedge clk);
        @(negedge clk);
        act_wr.delete();
        exp_wr.delete();
    endtask

    task automatic release_reset();
        @(negedge clk);
        tb_reset  = 1'b0;
        slave_clr = 1'b0;
    endtask

    task automatic test_reset();
        hold_reset(0);
        rdy_en = 2'b11; rv_en = 2'b11; tohost[0] = 64'd0; tohost[1] = 64'd0;
        n_tests++;
        if (req_valid !== 2'b00 || resp_ready !== 2'b00 || req_rw !== 1'b0 || req_addr !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_bus: valid=%b ready=%b rw=%b addr=%h, required all 0", req_valid, resp_ready, req_rw, req_addr);
        end
        n_tests++;
        if ({done, pass, fail, timeout, fail_core} !== 5'b0 || fail_code !== 63'd0 ||
            passed_mask !== 2'b00 || cycle_count !== 64'd0) begin
            n_fail++;
            $display("FAIL reset_status: d/p/f/t/fc=%b%b%b%b%b code=%h mask=%b cc=%0d, required all 0",
                     done, pass, fail, timeout, fail_core, fail_code, passed_mask, cycle_count);
        end
        // reset while a read response is outstanding
        rv_en = 2'b00;
        release_reset();
        begin
            int n = 0;
            while (resp_ready === 2'b00 && n < 10) begin @(negedge clk); n++; end
        end
        n_tests++;
        if (resp_ready !== 2'b01) begin
            n_fail++;
            $display("FAIL reset_mid_setup: resp_ready=%b, required 01", resp_ready);
        end
        tb_reset = 1'b1;
        @(posedge clk); #1;
        n_tests++;
        if (req_valid !== 2'b00 || resp_ready !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_mid_drop: valid=%b ready=%b, required 00 00", req_valid, resp_ready);
        end
        rv_en = 2'b11;
    endtask

    task automatic test_all_pass();
        hold_reset(0);
        tohost[0] = 64'd0; tohost[1] = 64'd0;
        release_reset();
        begin
            int n = 0;
            while ((rd_cnt[0] < 20 || rd_cnt[1] < 20) && n < 500) begin @(negedge clk); n++; end
            while (req_valid === 2'b00 && n < 510) begin @(negedge clk); n++; end
        end
        n_tests++;
        if (rd_cnt[0] < 20 || rd_cnt[1] < 20 || passed_mask !== 2'b00 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_polls: reads=%0d/%0d mask=%b done=%b, required >=20/>=20 00 0",
                     rd_cnt[0], rd_cnt[1], passed_mask, done);
        end
        n_tests++;
        if (req_addr !== 12'h780 || req_data !== 64'd0 || req_rw !== 1'b0) begin
            n_fail++;
            $display("FAIL req_fields: addr=%h data=%h rw=%b, required 780 0 0", req_addr, req_data, req_rw);
        end
        tohost[0] = 64'd1;
        exp_wr.push_back(0);
        begin
            int n = 0;
            while (passed_mask === 2'b00 && n < 50) begin @(negedge clk); n++; end
        end
        n_tests++;
        if (passed_mask !== 2'b01) begin
            n_fail++;
            $display("FAIL mask_core0: mask=%b, required 01", passed_mask);
        end
        tohost[1] = 64'd1;
        exp_wr.push_back(1);
        begin
            int n = 0;
            while (done !== 1'b1 && n < 60) begin @(negedge clk); n++; end
        end
        n_tests++;
        if (done !== 1'b1 || pass !== 1'b1 || fail !== 1'b0 || timeout !== 1'b0 || passed_mask !== 2'b11) begin
            n_fail++;
            $display("FAIL all_pass: done=%b pass=%b fail=%b to=%b mask=%b, required 1 1 0 0 11",
                     done, pass, fail, timeout, passed_mask);
        end
        while (exp_wr.size() > 0) begin
            int e = exp_wr.pop_front();
            int a = (act_wr.size() > 0) ? act_wr.pop_front() : -1;
            n_tests++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL pass_clear_write: core=%0d, required %0d", a, e);
            end
        end
        n_tests++;
        if (act_wr.size() != 0) begin
            n_fail++;
            $display("FAIL pass_extra_writes: %0d left, required 0", act_wr.size());
        end
    endtask

    task automatic test_fail_code();
        hold_reset(0);
        tohost[0] = 64'd0; tohost[1] = 64'h15;
        exp_wr.push_back(1);
        release_reset();
        begin
            int n = 0;
            while (done !== 1'b1 && n < 60) begin @(negedge clk); n++; end
        end
        n_tests++;
        if (done !== 1'b1 || fail !== 1'b1 || pass !== 1'b0 || timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL fail_flags: done=%b fail=%b pass=%b to=%b, required 1 1 0 0", done, fail, pass, timeout);
        end
        n_tests++;
        if (fail_core !== 1'b1 || fail_code !== 63'hA || passed_mask !== 2'b00) begin
            n_fail++;
            $display("FAIL fail_info: core=%0d code=%h mask=%b, required 1 a 00", fail_core, fail_code, passed_mask);
        end
        while (exp_wr.size() > 0) begin
            int e = exp_wr.pop_front();
            int a = (act_wr.size() > 0) ? act_wr.pop_front() : -1;
            n_tests++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL fail_clear_write: core=%0d, required %0d", a, e);
            end
        end
        n_tests++;
        if (act_wr.size() != 0) begin
            n_fail++;
            $display("FAIL fail_extra_writes: %0d left, required 0", act_wr.size());
        end
    endtask

    task automatic test_hs_timeout();
        hold_reset(0);
        tohost[0] = 64'd0; tohost[1] = 64'd0;
        rdy_en = 2'b10;
        release_reset();
        @(posedge clk); #1;
        n_tests++;
        if (req_valid !== 2'b01) begin
            n_fail++;
            $display("FAIL hs_req_start: valid=%b, required 01", req_valid);
        end
        repeat (255) @(posedge clk);
        #1;
        n_tests++;
        if (timeout !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL hs_early: timeout=%b done=%b at 255 cycles, required 0 0", timeout, done);
        end
        @(posedge clk); #1;
        n_tests++;
        if (timeout !== 1'b1 || done !== 1'b1 || fail_core !== 1'b0 || fail !== 1'b0 || req_valid !== 2'b00) begin
            n_fail++;
            $display("FAIL hs_timeout: to=%b done=%b core=%0d fail=%b valid=%b at 256 cycles, required 1 1 0 0 00",
                     timeout, done, fail_core, fail, req_valid);
        end
        rdy_en = 2'b11;
    endtask

    task automatic test_cycle_limit();
        logic [63:0] cc_s;
        hold_reset(1);
        tohost[0] = 64'd0; tohost[1] = 64'd0;
        release_reset();
        begin
            int n = 0;
            while (done !== 1'b1 && n < 300) begin @(negedge clk); n++; end
        end
        n_tests++;
        if (done !== 1'b1 || timeout !== 1'b1 || cycle_count !== 64'd100 || pass !== 1'b0 || fail !== 1'b0) begin
            n_fail++;
            $display("FAIL cycle_limit: done=%b to=%b cc=%0d pass=%b fail=%b, required 1 1 100 0 0",
                     done, timeout, cycle_count, pass, fail);
        end
        cc_s = cycle_count;
        repeat (10) @(negedge clk);
        n_tests++;
        if (cycle_count !== 64'd100 || resp_ready !== 2'b00 || req_valid !== 2'b00) begin
            n_fail++;
            $display("FAIL cycle_freeze: cc=%0d (was %0d) ready=%b valid=%b, required 100 00 00",
                     cycle_count, cc_s, resp_ready, req_valid);
        end
    endtask

    task automatic test_pause();
        logic [63:0] cc_s;
        logic [1:0]  rr_s;
        int          rd0, bad;
        hold_reset(0);
        tohost[0] = 64'd0; tohost[1] = 64'd0;
        rv_en = 2'b00;
        release_reset();
        begin
            int n = 0;
            while (resp_ready === 2'b00 && n < 10) begin @(negedge clk); n++; end
        end
        pause = 1'b1;
        cc_s  = cycle_count;
        rr_s  = resp_ready;
        rd0   = rd_cnt[0];
        bad   = 0;
        n_tests++;
        if (rr_s !== 2'b01) begin
            n_fail++;
            $display("FAIL pause_entry: resp_ready=%b, required 01", rr_s);
        end
        repeat (50) begin
            @(negedge clk);
            if (resp_ready !== rr_s || cycle_count !== cc_s) bad++;
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL pause_hold: %0d cycles changed, required 0", bad);
        end
        pause = 1'b0;
        rv_en = 2'b11;
        @(posedge clk); #1;
        n_tests++;
        if (rd_cnt[0] != rd0 + 1 || resp_ready !== 2'b00 || cycle_count !== cc_s + 64'd1) begin
            n_fail++;
            $display("FAIL pause_resume: reads=%0d ready=%b cc=%0d, required %0d 00 %0d",
                     rd_cnt[0], resp_ready, cycle_count, rd0 + 1, cc_s + 64'd1);
        end
        begin
            int n = 0;
            while (rd_cnt[1] < 1 && n < 20) begin @(negedge clk); n++; end
        end
        n_tests++;
        if (rd_cnt[1] < 1 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL pause_continue: core1 reads=%0d done=%b, required >=1 0", rd_cnt[1], done);
        end
    endtask

    task automatic test_no_clear();
        hold_reset(2);
        tohost[0] = 64'd1; tohost[1] = 64'd0;
        release_reset();
        repeat (90) @(negedge clk);
        n_tests++;
        if (saw_rw !== 1'b0 || act_wr.size() != 0) begin
            n_fail++;
            $display("FAIL noclr_write: rw_seen=%b writes=%0d, required 0 0", saw_rw, act_wr.size());
        end
        n_tests++;
        if (passed_mask !== 2'b01 || rd_cnt[0] != 1 || rd_cnt[1] < 20 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL noclr_poll: mask=%b reads=%0d/%0d done=%b, required 01 1/>=20 0",
                     passed_mask, rd_cnt[0], rd_cnt[1], done);
        end
    endtask

    initial begin
        tohost[0] = 64'd0;
        tohost[1] = 64'd0;
        test_reset();
        test_all_pass();
        test_fail_code();
        test_hs_timeout();
        test_cycle_limit();
        test_pause();
        test_no_clear();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/vscale_htif_multi_monitor.md
Name: vscale_htif_multi_monitor

Overview:
- Synthesizable host-side tohost monitor for 1..N vscale cores.
- Polls each core's tohost CSR round-robin over its HTIF PCR port, clears it after a nonzero read (optional), and aggregates pass/fail/timeout into one status word.
- Sits between the cores' HTIF PCR ports and the simulation/FPGA harness, replacing per-bench tohost polling.
- Adds multi-core support, handshake timeouts, a global cycle limit and pause.

Parameters:
- N_CORES, 2, number of monitored cores (1..16).
- PCR_WIDTH, 64, HTIF PCR data width.
- TOHOST_ADDR, 12'h780, CSR address polled.
- MAX_CYCLES, 0, global cycle limit; 0 disables the limit.
- RESP_TIMEOUT, 256, max cycles waiting for req_ready or resp_valid per transaction.
- CLEAR_TOHOST, 1, if 1 write 0 to tohost after each nonzero read.
- CORE_W, $clog2(N_CORES>1?N_CORES:2), core index width (derived).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- pause  in  1  1 = hold FSM, cycle counter and timeout counter
- htif_pcr_req_valid  out  N_CORES  per-core request valid
- htif_pcr_req_ready  in  N_CORES  per-core request ready
- htif_pcr_req_rw  out  1  1 = write (shared by all cores)
- htif_pcr_req_addr  out  12  always TOHOST_ADDR
- htif_pcr_req_data  out  PCR_WIDTH  write data, always 0
- htif_pcr_resp_valid  in  N_CORES  per-core response valid
- htif_pcr_resp_ready  out  N_CORES  per-core response ready
- htif_pcr_resp_data  in  N_CORES*PCR_WIDTH  core k occupies bits [k*PCR_WIDTH +: PCR_WIDTH]
- done  out  1  sticky; run finished
- pass  out  1  sticky; all cores wrote 1
- fail  out  1  sticky; some core wrote a value other than 0 or 1
- timeout  out  1  sticky; cycle or handshake timeout
- fail_core  out  CORE_W  index of the first failing or hung core
- fail_code  out  PCR_WIDTH-1  tohost>>1 of the failing core
- passed_mask  out  N_CORES  cores that have reported pass
- cycle_count  out  64  cycles since reset, excluding paused cycles

Behaviour:
- Reset (synchronous): FSM to REQ_RD with cur=0. All outputs are 0, including all valid/ready, rw, passed_mask and cycle_count.
- FSM states: REQ_RD, RESP_RD, REQ_WR, RESP_WR, NEXT, DONE.
- REQ_RD: req_valid[cur]=1, rw=0.
  - Transfer occurs on valid&ready[cur], then go to RESP_RD.
  - Only bit cur of req_valid is ever high.
- RESP_RD: resp_ready[cur]=1. On resp_valid[cur], sample data d:
  - d==0: go to NEXT.
  - d==1: set passed_mask[cur]; go to REQ_WR if CLEAR_TOHOST, else NEXT.
  - Any other value: fail=1, fail_core=cur, fail_code=d>>1. Go to REQ_WR if CLEAR_TOHOST, else DONE. After the clear write completes, go to DONE.
- REQ_WR/RESP_WR: same handshake as REQ_RD/RESP_RD with rw=1 and data=0. The response data is ignored.
- NEXT:
  - If passed_mask is all ones, set pass=1 and go to DONE.
  - Otherwise cur advances to the next index with passed_mask==0, wrapping modulo N_CORES, and the FSM goes to REQ_RD.
  - NEXT takes 1 cycle, so a single poll of an idle core costs at least 3 cycles.
- DONE: done=1, all valid/ready are 0, and the FSM stays until reset. cycle_count freezes.
- Handshake timeout:
  - The counter resets on every state entry.
  - If it reaches RESP_TIMEOUT in any REQ/RESP state: timeout=1, fail_core=cur, go to DONE.
- Global limit: MAX_CYCLES>0 and cycle_count==MAX_CYCLES-1 while not DONE gives timeout=1 and DONE on the next edge.
- Simultaneous events: a result sampled in RESP_RD takes priority over a global timeout in the same cycle. The fail/pass flags are still set, and timeout is also set.
- pause=1: outputs hold their current values. Counters and FSM do not advance. A handshake completing while paused is not consumed, because valid/ready are held and the transfer is taken on the first unpaused cycle.
- Reset mid-transaction drops valid/ready to 0 on the same edge. The bench must tolerate an abandoned request.
- Only the first failure is recorded in fail_core/fail_code.

Test Plan:
- N_CORES=2, both return 0 for 20 polls, then core0=1 and core1=1 -> passed_mask 01 then 11. pass=1, done=1, a 0-write is issued to each core, and no fail or timeout.
- Core1 returns 0x15 -> fail=1, fail_core=1, fail_code=0xA, and a clear write to core1, then done.
- Core0 holds req_ready=0 with RESP_TIMEOUT=256 -> timeout=1 and fail_core=0 exactly 256 cycles after REQ_RD entry.
- MAX_CYCLES=100 with all cores returning 0 -> timeout=1 and done=1 with cycle_count=100.
- pause=1 for 50 cycles mid-RESP_RD -> cycle_count is unchanged and resp_ready is held. Resumes with no lost transfer.
- CLEAR_TOHOST=0, core0 returns 1 -> no write (rw never 1), and polling continues on core1 only.
